// File: rtl/dag_circ_if.sv
// Request/write/readback bundle between the program sequencer, bus connect and the DAG.
interface dag_circ_if #(
    parameter int DA_WIDTH = 16,
    parameter int NUM_IREG = 8
);
    localparam int IDX_W = $clog2(NUM_IREG);

    logic                ps_dg_en;
    logic                ps_dg_mdfy;
    logic                ps_dg_brev;
    logic [IDX_W-1:0]    ps_dg_iadd;
    logic [IDX_W-1:0]    ps_dg_madd;
    logic                ps_dg_wrt_en;
    logic [IDX_W+1:0]    ps_dg_wrt_add;
    logic [IDX_W+1:0]    ps_dg_rd_add;
    logic [DA_WIDTH-1:0] bc_dt;
    logic [DA_WIDTH-1:0] dg_dm_add;
    logic [DA_WIDTH-1:0] dg_bc_dt;
    logic                dg_ps_wrap;

    modport master (
        output ps_dg_en, ps_dg_mdfy, ps_dg_brev, ps_dg_iadd, ps_dg_madd,
               ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
        input  dg_dm_add, dg_bc_dt, dg_ps_wrap
    );

    modport slave (
        input  ps_dg_en, ps_dg_mdfy, ps_dg_brev, ps_dg_iadd, ps_dg_madd,
               ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
        output dg_dm_add, dg_bc_dt, dg_ps_wrap
    );
endinterface

// File: rtl/dag_circ.sv
// Data address generator: I/M/L/B register sets, circular wrap inside [B, B+L),
// pre/post-modify and optional bit-reversed address output.
module dag_circ #(
    parameter int DA_WIDTH = 16,
    parameter int NUM_IREG = 8
) (
    input  logic        clk,
    input  logic        reset,
    dag_circ_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_IREG);

    function automatic logic [DA_WIDTH-1:0] bit_rev(input logic [DA_WIDTH-1:0] v);
        logic [DA_WIDTH-1:0] r;
        for (int k = 0; k < DA_WIDTH; k++) begin
            r[k] = v[DA_WIDTH-1-k];
        end
        return r;
    endfunction

    logic [DA_WIDTH-1:0] i_q [NUM_IREG];
    logic [DA_WIDTH-1:0] m_q [NUM_IREG];
    logic [DA_WIDTH-1:0] l_q [NUM_IREG];
    logic [DA_WIDTH-1:0] b_q [NUM_IREG];
    logic [DA_WIDTH-1:0] i_d [NUM_IREG];
    logic [DA_WIDTH-1:0] m_d [NUM_IREG];
    logic [DA_WIDTH-1:0] l_d [NUM_IREG];
    logic [DA_WIDTH-1:0] b_d [NUM_IREG];

    logic [DA_WIDTH-1:0] dm_add_q, dm_add_d;
    logic [DA_WIDTH-1:0] bc_dt_q, bc_dt_d;
    logic                wrap_q, wrap_d;

    logic [DA_WIDTH-1:0] i_cur_s, m_cur_s, l_cur_s, b_cur_s;
    logic [DA_WIDTH-1:0] sum_s, n_s, a_s;
    logic [DA_WIDTH:0]   limit_s;
    logic                wrap_s;
    logic                i_upd_s;
    logic [NUM_IREG-1:0] wr_i_s, wr_m_s, wr_l_s, wr_b_s;
    logic [IDX_W-1:0]    wr_set_s;
    logic [IDX_W-1:0]    rd_set_s;

    assign wr_set_s = bus.ps_dg_wrt_add[IDX_W-1:0];
    assign rd_set_s = bus.ps_dg_rd_add[IDX_W-1:0];

    // Index arithmetic; limit is one bit wider so B+L at the top of the space does not alias.
    always_comb begin
        i_cur_s = i_q[bus.ps_dg_iadd];
        m_cur_s = m_q[bus.ps_dg_madd];
        l_cur_s = l_q[bus.ps_dg_iadd];
        b_cur_s = b_q[bus.ps_dg_iadd];
        sum_s   = i_cur_s + m_cur_s;
        limit_s = {1'b0, b_cur_s} + {1'b0, l_cur_s};
        n_s     = sum_s;
        wrap_s  = 1'b0;
        if (l_cur_s == {DA_WIDTH{1'b0}}) begin
            n_s    = sum_s;
            wrap_s = 1'b0;
        end else if (!m_cur_s[DA_WIDTH-1] && ({1'b0, sum_s} >= limit_s)) begin
            n_s    = sum_s - l_cur_s;
            wrap_s = 1'b1;
        end else if (m_cur_s[DA_WIDTH-1] && (sum_s < b_cur_s)) begin
            n_s    = sum_s + l_cur_s;
            wrap_s = 1'b1;
        end else begin
            n_s    = sum_s;
            wrap_s = 1'b0;
        end
        a_s     = bus.ps_dg_mdfy ? n_s : i_cur_s;
        i_upd_s = bus.ps_dg_en & ~bus.ps_dg_mdfy;
    end

    // One-hot write strobes per register kind and set.
    always_comb begin
        wr_i_s = {NUM_IREG{1'b0}};
        wr_m_s = {NUM_IREG{1'b0}};
        wr_l_s = {NUM_IREG{1'b0}};
        wr_b_s = {NUM_IREG{1'b0}};
        if (bus.ps_dg_wrt_en) begin
            case (bus.ps_dg_wrt_add[IDX_W+1:IDX_W])
                2'b00:   wr_i_s[wr_set_s] = 1'b1;
                2'b01:   wr_m_s[wr_set_s] = 1'b1;
                2'b10:   wr_l_s[wr_set_s] = 1'b1;
                2'b11:   wr_b_s[wr_set_s] = 1'b1;
                default: wr_i_s = {NUM_IREG{1'b0}};
            endcase
        end else begin
            wr_i_s = {NUM_IREG{1'b0}};
        end
    end

    // Register file next state; a bus write overrides the post-modify update of the same I.
    always_comb begin
        for (int s = 0; s < NUM_IREG; s++) begin
            i_d[s] = wr_i_s[s] ? bus.bc_dt :
                     ((i_upd_s && (bus.ps_dg_iadd == IDX_W'(s))) ? n_s : i_q[s]);
            m_d[s] = wr_m_s[s] ? bus.bc_dt : m_q[s];
            l_d[s] = wr_l_s[s] ? bus.bc_dt : l_q[s];
            b_d[s] = wr_b_s[s] ? bus.bc_dt : b_q[s];
        end
    end

    // Output next state: address holds when idle, wrap is a single-generation pulse.
    always_comb begin
        dm_add_d = dm_add_q;
        wrap_d   = 1'b0;
        bc_dt_d  = {DA_WIDTH{1'b0}};
        if (bus.ps_dg_en) begin
            dm_add_d = bus.ps_dg_brev ? bit_rev(a_s) : a_s;
            wrap_d   = wrap_s;
        end else begin
            dm_add_d = dm_add_q;
            wrap_d   = 1'b0;
        end
        case (bus.ps_dg_rd_add[IDX_W+1:IDX_W])
            2'b00:   bc_dt_d = i_q[rd_set_s];
            2'b01:   bc_dt_d = m_q[rd_set_s];
            2'b10:   bc_dt_d = l_q[rd_set_s];
            2'b11:   bc_dt_d = b_q[rd_set_s];
            default: bc_dt_d = {DA_WIDTH{1'b0}};
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_IREG; s++) begin
                i_q[s] <= {DA_WIDTH{1'b0}};
                m_q[s] <= {DA_WIDTH{1'b0}};
                l_q[s] <= {DA_WIDTH{1'b0}};
                b_q[s] <= {DA_WIDTH{1'b0}};
            end
            dm_add_q <= {DA_WIDTH{1'b0}};
            bc_dt_q  <= {DA_WIDTH{1'b0}};
            wrap_q   <= 1'b0;
        end else begin
            for (int s = 0; s < NUM_IREG; s++) begin
                i_q[s] <= i_d[s];
                m_q[s] <= m_d[s];
                l_q[s] <= l_d[s];
                b_q[s] <= b_d[s];
            end
            dm_add_q <= dm_add_d;
            bc_dt_q  <= bc_dt_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.dg_dm_add  = dm_add_q;
    assign bus.dg_bc_dt   = bc_dt_q;
    assign bus.dg_ps_wrap = wrap_q;
endmodule

// File: tb/tb_dag_circ.sv
// Directed vector bench for dag_circ: one table row per clock, expected values hand-computed.
module tb_dag_circ;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    dag_circ_if #(.DA_WIDTH(16), .NUM_IREG(8)) bus ();

    dag_circ #(.DA_WIDTH(16), .NUM_IREG(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic        en;
        logic        md;
        logic        br;
        logic [2:0]  ia;
        logic [2:0]  ma;
        logic [4:0]  ra;
        logic [15:0] ea;
        logic        ew;
        logic [15:0] er;
    } vec_t;

    vec_t tbl [39];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.ps_dg_wrt_en  = v.we;
        bus.ps_dg_wrt_add = v.wa;
        bus.bc_dt         = v.wd;
        bus.ps_dg_en      = v.en;
        bus.ps_dg_mdfy    = v.md;
        bus.ps_dg_brev    = v.br;
        bus.ps_dg_iadd    = v.ia;
        bus.ps_dg_madd    = v.ma;
        bus.ps_dg_rd_add  = v.ra;
        @(posedge clk);
        #1;
        check({tag, ".dm_add"}, bus.dg_dm_add, v.ea);
        check({tag, ".wrap"}, {15'd0, bus.dg_ps_wrap}, {15'd0, v.ew});
        check({tag, ".rdback"}, bus.dg_bc_dt, v.er);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, ".dm_add"}, bus.dg_dm_add, 16'h0000);
        check({tag, ".wrap"}, {15'd0, bus.dg_ps_wrap}, 16'h0000);
        check({tag, ".rdback"}, bus.dg_bc_dt, 16'h0000);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        // Register map: I=set, M=8+set, L=16+set, B=24+set
        //              we    wa     wd        en    md    br    ia    ma    ra     ea         ew    er
        tbl[0]  = '{1'b1, 5'd0,  16'h0010, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 5'd8,  16'h0003, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0000, 1'b0, 16'h0010};
        tbl[2]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd8,  16'h0010, 1'b0, 16'h0003};
        tbl[3]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0013, 1'b0, 16'h0013};
        tbl[4]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0016, 1'b0, 16'h0016};
        tbl[5]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0019, 1'b0, 16'h0019};
        tbl[6]  = '{1'b1, 5'd25, 16'h0100, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0019, 1'b0, 16'h001C};
        tbl[7]  = '{1'b1, 5'd17, 16'h0005, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd25, 16'h0019, 1'b0, 16'h0100};
        tbl[8]  = '{1'b1, 5'd1,  16'h0103, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd17, 16'h0019, 1'b0, 16'h0005};
        tbl[9]  = '{1'b1, 5'd9,  16'h0002, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd1,  16'h0019, 1'b0, 16'h0103};
        // Circular forward: 0x103+2 hits B+L and wraps, later 0x104+2 wraps again
        tbl[10] = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 5'd9,  16'h0103, 1'b1, 16'h0002};
        tbl[11] = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 5'd1,  16'h0100, 1'b0, 16'h0100};
        tbl[12] = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 5'd1,  16'h0102, 1'b0, 16'h0102};
        tbl[13] = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 5'd1,  16'h0104, 1'b1, 16'h0104};
        tbl[14] = '{1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 5'd1,  16'h0104, 1'b0, 16'h0101};
        tbl[15] = '{1'b1, 5'd26, 16'h0040, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd26, 16'h0104, 1'b0, 16'h0000};
        tbl[16] = '{1'b1, 5'd18, 16'h0004, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd26, 16'h0104, 1'b0, 16'h0040};
        tbl[17] = '{1'b1, 5'd2,  16'h0040, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd18, 16'h0104, 1'b0, 16'h0004};
        tbl[18] = '{1'b1, 5'd10, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd2,  16'h0104, 1'b0, 16'h0040};
        // Circular backward, pre-modify: 0x40-1 < B wraps to 0x43, I2 untouched
        tbl[19] = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b1, 1'b0, 3'd2, 3'd2, 5'd10, 16'h0043, 1'b1, 16'hFFFF};
        tbl[20] = '{1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 3'd2, 3'd2, 5'd2,  16'h0043, 1'b0, 16'h0040};
        tbl[21] = '{1'b1, 5'd3,  16'h0001, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd3,  16'h0043, 1'b0, 16'h0000};
        tbl[22] = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 5'd3,  16'h8000, 1'b0, 16'h0001};
        tbl[23] = '{1'b1, 5'd3,  16'h0006, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd3,  16'h8000, 1'b0, 16'h0001};
        tbl[24] = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 5'd3,  16'h6000, 1'b0, 16'h0006};
        tbl[25] = '{1'b1, 5'd0,  16'h0020, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h6000, 1'b0, 16'h001C};
        tbl[26] = '{1'b1, 5'd8,  16'h0001, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h6000, 1'b0, 16'h0020};
        // Write of I0 collides with its post-modify update: write wins
        tbl[27] = '{1'b1, 5'd0,  16'h0050, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0020, 1'b0, 16'h0020};
        tbl[28] = '{1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0020, 1'b0, 16'h0050};
        tbl[29] = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd8,  16'h0050, 1'b0, 16'h0001};
        // M0 written during generation: this generation still adds the old M0=1
        tbl[30] = '{1'b1, 5'd8,  16'h0005, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0051, 1'b0, 16'h0051};
        tbl[31] = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd8,  16'h0052, 1'b0, 16'h0005};
        tbl[32] = '{1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0052, 1'b0, 16'h0057};
        tbl[33] = '{1'b1, 5'd28, 16'hFFF0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0,  16'h0052, 1'b0, 16'h0057};
        tbl[34] = '{1'b1, 5'd20, 16'h0010, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd28, 16'h0052, 1'b0, 16'hFFF0};
        tbl[35] = '{1'b1, 5'd4,  16'hFFFE, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd20, 16'h0052, 1'b0, 16'h0010};
        tbl[36] = '{1'b1, 5'd12, 16'h0001, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd4,  16'h0052, 1'b0, 16'hFFFE};
        // B+L = 0x10000: 0xFFFF must not be seen as past the end
        tbl[37] = '{1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 3'd4, 3'd4, 5'd12, 16'hFFFE, 1'b0, 16'h0001};
        tbl[38] = '{1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 3'd4, 3'd4, 5'd4,  16'hFFFE, 1'b0, 16'hFFFF};

        reset             = 1'b0;
        bus.ps_dg_en      = 1'b0;
        bus.ps_dg_mdfy    = 1'b0;
        bus.ps_dg_brev    = 1'b0;
        bus.ps_dg_iadd    = 3'd0;
        bus.ps_dg_madd    = 3'd0;
        bus.ps_dg_wrt_en  = 1'b0;
        bus.ps_dg_wrt_add = 5'd0;
        bus.ps_dg_rd_add  = 5'd0;
        bus.bc_dt         = 16'h0000;
        #22;
        check_outs_zero("por");
        @(negedge clk);
        reset = 1'b1;

        // Load I0, generate once, then pull reset mid-sequence
        apply('{1'b1, 5'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0, 16'h0000}, "rst_load");
        apply('{1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 16'h1234, 1'b0, 16'h1234}, "rst_gen");
        #2;
        reset = 1'b0;
        #1;
        check_outs_zero("rst_async");
        @(negedge clk);
        reset = 1'b1;
        apply('{1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0, 16'h0000}, "rst_rdI0");
        apply('{1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0, 16'h0000}, "rst_gen0");

        for (int i = 0; i < 39; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
